cmp_frame_tally: RTL and testbench

Downstream consumer of the 4-bit signed comparator stage. It accepts one operand pair per handshake, together with the comparator's `res` bit, and tallies FRAME_LEN pairs into a frame summary: less/equal/greater counts and the signed min/max of operand `a`. It independently re-checks every `res` against a local signed compare and flags disagreement, which catches unsigned-compare bugs such as 4 < -1 being reported true. The summary is presented on a valid/ready output and held until consumed.

---
 rtl/cmp_frame_tally.sv | 135 +++++++++++++
 tb/tb_cmp_frame_tally.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cmp_frame_tally.sv
// cmp_frame_tally: tallies FRAME_LEN signed operand pairs into a lt/eq/gt/min/max/err frame summary.
// Ports: clk_i, rst_ni (async active-low), clr_i (sync frame abort);
//   input pair handshake in_valid_i/in_ready_o with in_a_i, in_b_i, in_res_i;
//   summary handshake out_valid_o/out_ready_i with out_lt_cnt_o, out_eq_cnt_o,
//   out_gt_cnt_o, out_min_a_o, out_max_a_o, out_err_o.
module cmp_frame_tally #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_a_i,
  input  logic [3:0]       in_b_i,
  input  logic             in_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_lt_cnt_o,
  output logic [CNT_W-1:0] out_eq_cnt_o,
  output logic [CNT_W-1:0] out_gt_cnt_o,
  output logic [3:0]       out_min_a_o,
  output logic [3:0]       out_max_a_o,
  output logic             out_err_o
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [CNT_W-1:0] olt_q, olt_d, oeq_q, oeq_d, ogt_q, ogt_d;
  logic signed [3:0] min_q, min_d, max_q, max_d, omin_q, omin_d, omax_q, omax_d;
  logic err_q, err_d, oerr_q, oerr_d;
  logic signed [3:0] a, b, min_n, max_n;
  logic [CNT_W-1:0] lt_n, eq_n, gt_n;
  logic lt, eq, acc, first, last, err_n;
  assign a = $signed(in_a_i);
  assign b = $signed(in_b_i);
  assign lt = a < b;
  assign eq = a == b;
  assign in_ready_o = state_q == COLLECT;
  assign out_valid_o = state_q == HOLD;
  assign acc = in_valid_i && in_ready_o;
  assign first = idx_q == '0;
  assign last = idx_q == CNT_W'(FRAME_LEN - 1);
  // Running values including the pair currently presented.
  assign lt_n = lt_q + CNT_W'(lt);
  assign eq_n = eq_q + CNT_W'(eq);
  assign gt_n = gt_q + CNT_W'(!lt && !eq);
  assign min_n = (first || a < min_q) ? a : min_q;
  assign max_n = (first || a > max_q) ? a : max_q;
  assign err_n = err_q | (in_res_i != lt);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    lt_d = lt_q;
    eq_d = eq_q;
    gt_d = gt_q;
    min_d = min_q;
    max_d = max_q;
    err_d = err_q;
    olt_d = olt_q;
    oeq_d = oeq_q;
    ogt_d = ogt_q;
    omin_d = omin_q;
    omax_d = omax_q;
    oerr_d = oerr_q;
    if (clr_i || (acc && last)) begin
      state_d = clr_i ? COLLECT : HOLD;
      idx_d = '0;
      lt_d = '0;
      eq_d = '0;
      gt_d = '0;
      min_d = '0;
      max_d = '0;
      err_d = 1'b0;
      if (!clr_i) begin
        olt_d = lt_n;
        oeq_d = eq_n;
        ogt_d = gt_n;
        omin_d = min_n;
        omax_d = max_n;
        oerr_d = err_n;
      end
    end else if (acc) begin
      idx_d = idx_q + CNT_W'(1);
      lt_d = lt_n;
      eq_d = eq_n;
      gt_d = gt_n;
      min_d = min_n;
      max_d = max_n;
      err_d = err_n;
    end else if (out_valid_o && out_ready_i) begin
      state_d = COLLECT;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      idx_q <= '0;
      lt_q <= '0;
      eq_q <= '0;
      gt_q <= '0;
      min_q <= '0;
      max_q <= '0;
      err_q <= 1'b0;
      olt_q <= '0;
      oeq_q <= '0;
      ogt_q <= '0;
      omin_q <= '0;
      omax_q <= '0;
      oerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
      gt_q <= gt_d;
      min_q <= min_d;
      max_q <= max_d;
      err_q <= err_d;
      olt_q <= olt_d;
      oeq_q <= oeq_d;
      ogt_q <= ogt_d;
      omin_q <= omin_d;
      omax_q <= omax_d;
      oerr_q <= oerr_d;
    end
  end
  assign out_lt_cnt_o = olt_q;
  assign out_eq_cnt_o = oeq_q;
  assign out_gt_cnt_o = ogt_q;
  assign out_min_a_o = omin_q;
  assign out_max_a_o = omax_q;
  assign out_err_o = oerr_q;
endmodule

// File: tb/tb_cmp_frame_tally.sv
// tb_cmp_frame_tally: directed and randomized check of cmp_frame_tally against a frame-level model.
module tb_cmp_frame_tally;
  localparam int FL = 4;
  localparam int CW = 8;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, in_res = 0, out_ready = 0;
  logic [3:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_err;
  logic [CW-1:0] out_lt, out_eq, out_gt;
  logic [3:0] out_min, out_max;
  int n_chk = 0, n_fail = 0;

  cmp_frame_tally #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_res_i(in_res),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_lt_cnt_o(out_lt), .out_eq_cnt_o(out_eq), .out_gt_cnt_o(out_gt),
    .out_min_a_o(out_min), .out_max_a_o(out_max), .out_err_o(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: store the pairs of the current frame, summarise them when complete.
  int fa[FL], fb[FL], fr[FL];
  int n, m_lt, m_eq, m_gt, m_min, m_max, m_err;
  bit m_hold;

  task automatic summarize();
    m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0;
    m_min = fa[0]; m_max = fa[0];
    for (int i = 0; i < FL; i++) begin
      if (fa[i] < fb[i]) m_lt++;
      else if (fa[i] == fb[i]) m_eq++;
      else m_gt++;
      if (fr[i] != int'(fa[i] < fb[i])) m_err = 1;
      if (fa[i] < m_min) m_min = fa[i];
      if (fa[i] > m_max) m_max = fa[i];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_hold = 0; m_lt = 0; m_eq = 0; m_gt = 0; m_min = 0; m_max = 0; m_err = 0;
    end else if (clr) begin
      n = 0; m_hold = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      fa[n] = $signed(in_a); fb[n] = $signed(in_b); fr[n] = int'(in_res);
      n++;
      if (n == FL) begin
        summarize();
        n = 0;
        m_hold = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      chk("lt_cnt", int'(out_lt), m_lt);
      chk("eq_cnt", int'(out_eq), m_eq);
      chk("gt_cnt", int'(out_gt), m_gt);
      chk("min_a", $signed(out_min), m_min);
      chk("max_a", $signed(out_max), m_max);
      chk("err", int'(out_err), m_err);
    end
  end

  task automatic step(input logic v, input int a, input int b, input logic r);
    in_valid = v; in_a = 4'(a); in_b = 4'(b); in_res = r;
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input int lt, input int eq, input int gt,
                     input int mn, input int mx, input int er);
    chk({tag, " valid"}, int'(out_valid), 1);
    chk({tag, " lt"}, int'(out_lt), lt);
    chk({tag, " eq"}, int'(out_eq), eq);
    chk({tag, " gt"}, int'(out_gt), gt);
    chk({tag, " min"}, $signed(out_min), mn);
    chk({tag, " max"}, $signed(out_max), mx);
    chk({tag, " err"}, int'(out_err), er);
  endtask

  initial begin
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst counts", int'(out_lt) + int'(out_eq) + int'(out_gt), 0);
    chk("rst minmax", int'(out_min) + int'(out_max) + int'(out_err), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst in_ready", int'(in_ready), 1);
    out_ready = 1;
    step(1, 4, 1, 0); step(1, 4, -1, 0); step(1, -3, 2, 1); step(1, 2, 2, 0);
    lit("normal", 1, 1, 2, -3, 4, 0);
    step(0, 0, 0, 0);
    chk("normal ready after", int'(in_ready), 1);
    step(1, 4, -1, 1); step(1, 0, 0, 0); step(1, 1, 2, 1); step(1, -8, 7, 1);
    lit("unsigned", 2, 1, 1, -8, 4, 1);
    step(0, 0, 0, 0);
    step(1, 4, 1, 0); step(0, 0, 0, 0); step(1, 4, -1, 0); step(0, 0, 0, 0);
    step(1, -3, 2, 1); step(0, 0, 0, 0); step(1, 2, 2, 0);
    lit("gapped", 1, 1, 2, -3, 4, 0);
    step(0, 0, 0, 0);
    out_ready = 0;
    step(1, 4, 1, 0); step(1, 4, -1, 0); step(1, -3, 2, 1); step(1, 2, 2, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 3, 5, 1);
      chk("bp ready low", int'(in_ready), 0);
      lit("bp", 1, 1, 2, -3, 4, 0);
    end
    out_ready = 1;
    step(1, 3, 5, 1);
    chk("bp released", int'(out_valid), 0);
    chk("bp pair pending", n, 0);
    step(1, 3, 5, 1);
    chk("bp pair taken", n, 1);
    step(1, 1, 1, 0); step(1, 2, 0, 0);
    clr = 1;
    step(1, 5, 5, 0);
    clr = 0;
    for (int i = 0; i < FL; i++) step(1, -1, -1, 0);
    lit("clr", 0, 4, 0, -1, -1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int a, b;
      a = $urandom_range(15) - 8;
      b = $urandom_range(15) - 8;
      out_ready = ($urandom_range(3) != 0);
      clr = ($urandom_range(39) == 0);
      step($urandom_range(3) != 0, a, b, (a < b) ^ ($urandom_range(9) == 0));
    end
    clr = 0; out_ready = 0;
    step(0, 0, 0, 0);
    for (int i = 0; i < FL; i++) step(1, 6, -2, 0);
    chk("hold before reset", int'(out_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async counts", int'(out_lt) + int'(out_eq) + int'(out_gt), 0);
    chk("async minmax", int'(out_min) + int'(out_max) + int'(out_err), 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 0);
    chk("post reset ready", int'(in_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
